// File: rtl/m_bit_rx_pkg.sv
// Shared types and constants for the m-bit serial word receiver.
package m_bit_rx_pkg;

    localparam int unsigned M_DEFAULT = 10;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/m_bit_shift_receiver_shift_capture_core.sv
// Directional shift register plus bit counter that rebuilds one serial word.
// With PARITY_CHK_EN defined, a trailing parity slot is counted but not shifted in.
module shift_capture_core
    import m_bit_rx_pkg::*;
#(
    parameter int unsigned M     = M_DEFAULT,
    parameter int unsigned CNT_W = $clog2(M + 2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         dir_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [M-1:0] word_c_o,
    output logic         done_c_o
);

`ifdef PARITY_CHK_EN
    localparam int unsigned LAST = M;
`else
    localparam int unsigned LAST = M - 1;
`endif

    logic [M-1:0]     sr_q, sr_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             data_slot;

    // Only the first M qualified samples are data; anything after is the parity slot.
    assign data_slot = (cnt_q < CNT_W'(M));
    assign shifted   = (dir_q == DIR_MSB) ? {sr_q[M-2:0], bit_i} : {bit_i, sr_q[M-1:1]};
    assign word_c_o  = (en_i && data_slot) ? shifted : sr_q;
    assign done_c_o  = en_i && (cnt_q == CNT_W'(LAST));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
            dir_d = dir_i;
        end else if (en_i) begin
            sr_d = word_c_o;
            // Counter parks on its final value so it never runs past the word.
            if (!done_c_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            dir_q <= DIR_LSB;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

endmodule

// File: rtl/m_bit_shift_receiver.sv
// Serial-to-parallel receiver: rebuilds M-bit words and hands them off on valid/ready.
// Optional even-parity check on a trailing bit is enabled by defining PARITY_CHK_EN.
module m_bit_shift_receiver
    import m_bit_rx_pkg::*;
#(
    parameter int unsigned M     = M_DEFAULT,
    parameter int unsigned CNT_W = $clog2(M + 2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dir,
    input  logic         sin,
    input  logic         sin_vld,
    output logic [M-1:0] op,
    output logic         op_vld,
    input  logic         op_rdy,
    output logic         busy,
    output logic         ovr,
    output logic         par_err
);

    state_e       state_q, state_d;
    logic [M-1:0] op_q, op_d;
    logic         op_vld_q, op_vld_d;
    logic         busy_q, busy_d;
    logic         ovr_q, ovr_d;
    logic         par_err_q, par_err_d;

    logic         clr_c, en_c;
    logic [M-1:0] core_word_c;
    logic         core_done_c;
    logic         par_bit_c;

    // A start is honoured everywhere except while a word waits unaccepted in HOLD.
    assign clr_c = start && ((state_q != HOLD) || op_rdy);
    assign en_c  = (state_q == SHIFT) && sin_vld && !start;

`ifdef PARITY_CHK_EN
    assign par_bit_c = ^{core_word_c, sin};
`else
    assign par_bit_c = 1'b0;
`endif

    shift_capture_core #(
        .M     (M),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_c),
        .dir_i    (dir),
        .en_i     (en_c),
        .bit_i    (sin),
        .word_c_o (core_word_c),
        .done_c_o (core_done_c)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op_vld_d  = op_vld_q;
        ovr_d     = ovr_q;
        par_err_d = par_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    ovr_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (start) begin
                    ovr_d = 1'b0;
                end else if (en_c && core_done_c) begin
                    state_d   = HOLD;
                    op_d      = core_word_c;
                    op_vld_d  = 1'b1;
                    par_err_d = par_bit_c;
                end
            end
            HOLD: begin
                // Bits arriving with no room are dropped and flagged.
                if (sin_vld) begin
                    ovr_d = 1'b1;
                end
                if (op_rdy) begin
                    op_vld_d  = 1'b0;
                    par_err_d = 1'b0;
                    if (start) begin
                        state_d = SHIFT;
                        ovr_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            op_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op_vld_q  <= op_vld_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            par_err_q <= par_err_d;
        end
    end

    assign op      = op_q;
    assign op_vld  = op_vld_q;
    assign busy    = busy_q;
    assign ovr     = ovr_q;
    assign par_err = par_err_q;

endmodule

// File: tb/tb_m_bit_shift_receiver.sv
// Directed bench for m_bit_shift_receiver: table of words plus hand-written corner sequences.
module tb_m_bit_shift_receiver;

`ifdef PARITY_CHK_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic       sin = 1'b0;
    logic       sin_vld = 1'b0;
    logic       op_rdy = 1'b0;
    logic [9:0] op;
    logic       op_vld, busy, ovr, par_err;

    int n_tests = 0;
    int n_fail  = 0;

    m_bit_shift_receiver dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dir     (dir),
        .sin     (sin),
        .sin_vld (sin_vld),
        .op      (op),
        .op_vld  (op_vld),
        .op_rdy  (op_rdy),
        .busy    (busy),
        .ovr     (ovr),
        .par_err (par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic       dir;
        logic [9:0] stream;   // stream[i] is the i-th bit sent
        logic       gaps;
        logic [9:0] exp_op;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_word(input logic d, output int busy_cnt);
        start = 1'b1;
        dir   = d;
        tick();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
    endtask

    task automatic send_word(input logic [9:0] s, input logic gaps, input logic pbit,
                             output int busy_cnt, output logic vld_before_last);
        logic [10:0] sx;
        sx = {pbit, s};
        busy_cnt = 0;
        vld_before_last = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                sin_vld = 1'b0;
                sin     = ~sx[i];
                tick();
                if (busy) busy_cnt++;
            end
            if (i == NB - 1) vld_before_last = op_vld;
            sin_vld = 1'b1;
            sin     = sx[i];
            tick();
            if (busy) busy_cnt++;
        end
        sin_vld = 1'b0;
        sin     = 1'b0;
    endtask

    task automatic accept(input string nm);
        op_rdy = 1'b1;
        tick();
        op_rdy = 1'b0;
        chk({nm, "_vld_drop"}, op_vld, 0);
    endtask

    initial begin
        int   bs, bc;
        logic pre;
        logic stable;

        vecs[0] = '{"t1_lsb_206",  1'b0, 10'h206, 1'b0, 10'h206};
        vecs[1] = '{"t2_msb_206",  1'b1, 10'h206, 1'b0, 10'h181};
        vecs[2] = '{"lsb_3ff",     1'b0, 10'h3FF, 1'b0, 10'h3FF};
        vecs[3] = '{"msb_first1",  1'b1, 10'h001, 1'b0, 10'h200};
        vecs[4] = '{"msb_0f0",     1'b1, 10'h0F0, 1'b0, 10'h03C};
        vecs[5] = '{"msb_2aa",     1'b1, 10'h2AA, 1'b0, 10'h155};
        vecs[6] = '{"gap_lsb_206", 1'b0, 10'h206, 1'b1, 10'h206};
        vecs[7] = '{"gap_msb_206", 1'b1, 10'h206, 1'b1, 10'h181};

        // Reset state
        tick();
        tick();
        chk("rst_op", op, 0);
        chk("rst_vld", op_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_par", par_err, 0);
        rst = 1'b0;
        tick();

        // Table-driven words
        for (int v = 0; v < 8; v++) begin
            start_word(vecs[v].dir, bs);
            send_word(vecs[v].stream, vecs[v].gaps, ^vecs[v].stream, bc, pre);
            chk({vecs[v].name, "_vld_pre"}, pre, 0);
            chk({vecs[v].name, "_vld"}, op_vld, 1);
            chk({vecs[v].name, "_op"}, op, vecs[v].exp_op);
            chk({vecs[v].name, "_par"}, par_err, 0);
            chk({vecs[v].name, "_busy_now"}, busy, 0);
            if (!vecs[v].gaps) chk({vecs[v].name, "_busy_cycles"}, bs + bc, NB);
            accept(vecs[v].name);
        end

        // T3: held output, overrun in HOLD, ovr cleared by next start
        start_word(1'b0, bs);
        send_word(10'h206, 1'b0, 1'b1, bc, pre);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sin_vld = (c == 2);
            sin     = 1'b1;
            tick();
            if (op !== 10'h206 || op_vld !== 1'b1) stable = 1'b0;
        end
        sin_vld = 1'b0;
        chk("t3_hold_stable", stable, 1);
        chk("t3_ovr_set", ovr, 1);
        accept("t3");
        chk("t3_ovr_sticky", ovr, 1);
        chk("t3_op_kept", op, 10'h206);
        start_word(1'b0, bs);
        chk("t3_ovr_clr", ovr, 0);
        send_word(10'h0F0, 1'b0, 1'b0, bc, pre);
        chk("t3_next_op", op, 10'h0F0);
        chk("t3_no_ovr", ovr, 0);
        accept("t3b");

        // T4: reset mid-capture discards the partial word
        start_word(1'b0, bs);
        sin_vld = 1'b1;
        sin     = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        sin_vld = 1'b0;
        rst = 1'b1;
        tick();
        chk("t4_rst_op", op, 0);
        chk("t4_rst_vld", op_vld, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ovr", ovr, 0);
        rst = 1'b0;
        sin_vld = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (op_vld !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        sin_vld = 1'b0;
        chk("t4_idle_ignores_sin", stable, 1);
        start_word(1'b0, bs);
        send_word(10'h3FF, 1'b0, 1'b0, bc, pre);
        chk("t4_ones_vld", op_vld, 1);
        chk("t4_ones_op", op, 10'h3FF);
        accept("t4");

        // T5: back-to-back accept and start, no lost bit
        start_word(1'b0, bs);
        send_word(10'h206, 1'b0, 1'b1, bc, pre);
        chk("t5_first_op", op, 10'h206);
        op_rdy = 1'b1;
        start  = 1'b1;
        dir    = 1'b1;
        tick();
        op_rdy = 1'b0;
        start  = 1'b0;
        chk("t5_b2b_vld", op_vld, 0);
        chk("t5_b2b_busy", busy, 1);
        send_word(10'h2AA, 1'b0, 1'b1, bc, pre);
        chk("t5_second_vld", op_vld, 1);
        chk("t5_second_op", op, 10'h155);
        accept("t5");

        // Restart during SHIFT re-latches dir and discards partial bits
        start_word(1'b0, bs);
        sin_vld = 1'b1;
        sin     = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sin_vld = 1'b0;
        start_word(1'b1, bs);
        send_word(10'h206, 1'b0, 1'b1, bc, pre);
        chk("restart_vld_pre", pre, 0);
        chk("restart_op", op, 10'h181);
        accept("restart");

        // Start and sin_vld together in IDLE: that bit is not captured
        start   = 1'b1;
        dir     = 1'b0;
        sin_vld = 1'b1;
        sin     = 1'b1;
        tick();
        start   = 1'b0;
        sin_vld = 1'b0;
        send_word(10'h000, 1'b0, 1'b0, bc, pre);
        chk("idle_start_sin_vld_pre", pre, 0);
        chk("idle_start_sin_op", op, 10'h000);
        chk("idle_start_sin_ovr", ovr, 0);
        accept("idle_start_sin");

`ifdef PARITY_CHK_EN
        // T6: parity mismatch and match on an all-ones word
        start_word(1'b0, bs);
        send_word(10'h3FF, 1'b0, 1'b1, bc, pre);
        chk("t6_bad_op", op, 10'h3FF);
        chk("t6_bad_par", par_err, 1);
        accept("t6a");
        start_word(1'b0, bs);
        send_word(10'h3FF, 1'b0, 1'b0, bc, pre);
        chk("t6_good_op", op, 10'h3FF);
        chk("t6_good_par", par_err, 0);
        accept("t6b");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
